// File: rtl/sys_pkg.sv
// sys_pkg: FSM state encodings, default PC width and run-period clamp shared by sys_step_ctrl
package sys_pkg;
  localparam int unsigned SYS_PC_W = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STEP = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_LOAD = 2'd3;
  // Run period is the base divider shifted by the rate select, never shorter than one cycle.
  function automatic int unsigned run_period(input int unsigned div, input logic [1:0] sel);
    int unsigned p;
    p = div >> sel;
    return (p == 32'd0) ? 32'd1 : p;
  endfunction
endpackage

// File: rtl/sys_debounce.sv
// sys_debounce: 2-flop synchroniser and stable-count filter giving a clean level from a raw board input
module sys_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter logic        RST_VAL      = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYC) + 1;
  logic          r_s0;
  logic          r_s1;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  assign o_level = r_level;
  // two-stage synchroniser for the asynchronous pin
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_s0 <= RST_VAL;
      r_s1 <= RST_VAL;
    end else begin
      r_s0 <= i_raw;
      r_s1 <= r_s0;
    end
  // accept the new level after DEBOUNCE_CYC consecutive samples that disagree with the current one
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_level <= RST_VAL;
    end else if (r_s1 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
      r_cnt   <= '0;
      r_level <= r_s1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/sys_step_ctrl.sv
// sys_step_ctrl: turns debounced step/run/load controls into step_en and pc_load strobes for the core
// Optional build macro SYS_STEP_BREAKPOINT_EN adds bp_addr/bp_valid to halt free-run at a PC.
module sys_step_ctrl
  import sys_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned RUN_DIV      = 12500000,
  parameter int unsigned PC_W         = SYS_PC_W,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             SYS_clk,
  input  logic             SYS_rst,
  input  logic             key_step_n,
  input  logic             sw_run,
  input  logic             sw_load,
  input  logic [PC_W-1:0]  load_val,
  input  logic [1:0]       rate_sel,
  input  logic [PC_W-1:0]  pc_current,
`ifdef SYS_STEP_BREAKPOINT_EN
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid,
`endif
  output logic             step_en,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_load_val,
  output logic             busy,
  output logic [CNT_W-1:0] step_count,
  output logic [1:0]       state_o
);
  localparam int unsigned RW = $clog2(RUN_DIV) + 1;
  logic             w_key_lvl;
  logic             w_run;
  logic             w_load_lvl;
  logic             r_key_prev;
  logic             r_load_prev;
  logic             w_press;
  logic             w_load_req;
  logic             w_run_ok;
  logic             w_bp_hit;
  logic             w_tc;
  logic             w_tick;
  logic             w_halt;
  logic             w_step_en;
  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [RW-1:0]    r_rate;
  logic [RW-1:0]    w_period;
  logic [CNT_W-1:0] r_count;
  logic [PC_W-1:0]  r_pc_val;

  sys_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL(1'b1)) u_db_key (
    .i_clk(SYS_clk), .i_rst_n(SYS_rst), .i_raw(key_step_n), .o_level(w_key_lvl)
  );
  sys_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL(1'b0)) u_db_run (
    .i_clk(SYS_clk), .i_rst_n(SYS_rst), .i_raw(sw_run), .o_level(w_run)
  );
  sys_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL(1'b0)) u_db_load (
    .i_clk(SYS_clk), .i_rst_n(SYS_rst), .i_raw(sw_load), .o_level(w_load_lvl)
  );

  assign w_press    = r_key_prev & ~w_key_lvl;
  assign w_load_req = ~r_load_prev & w_load_lvl;
  assign w_period   = RW'(run_period(RUN_DIV, rate_sel));
  assign w_tc       = r_rate >= (w_period - 1'b1);
  assign w_tick     = (r_state == ST_RUN) && w_run && !w_load_req && w_tc;
  assign w_halt     = w_tick && w_bp_hit;
  assign w_step_en  = (r_state == ST_STEP) || (w_tick && !w_bp_hit);

`ifdef SYS_STEP_BREAKPOINT_EN
  logic r_bp_hold;
  assign w_bp_hit = bp_valid && (pc_current == bp_addr);
  assign w_run_ok = w_run && !r_bp_hold;
  // a breakpoint halt blocks re-entering RUN until sw_run has been dropped
  always_ff @(posedge SYS_clk or negedge SYS_rst)
    if (!SYS_rst) r_bp_hold <= 1'b0;
    else if (w_halt) r_bp_hold <= 1'b1;
    else if (!w_run) r_bp_hold <= 1'b0;
`else
  logic w_unused;
  assign w_unused = ^pc_current;
  assign w_bp_hit = 1'b0;
  assign w_run_ok = w_run;
`endif

  // next state: load beats run beats step
  always_comb
    w_next = (r_state == ST_IDLE) ? (w_load_req ? ST_LOAD : w_run_ok ? ST_RUN : w_press ? ST_STEP : ST_IDLE)
           : (r_state == ST_STEP) ? ST_IDLE
           : (r_state == ST_RUN)  ? (w_load_req ? ST_LOAD : (!w_run || w_halt) ? ST_IDLE : ST_RUN)
           : (w_run_ok ? ST_RUN : ST_IDLE);

  // state register and debounced-level history for edge detection
  always_ff @(posedge SYS_clk or negedge SYS_rst)
    if (!SYS_rst) begin
      r_state     <= ST_IDLE;
      r_key_prev  <= 1'b1;
      r_load_prev <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_key_prev  <= w_key_lvl;
      r_load_prev <= w_load_lvl;
    end

  // rate counter runs only in RUN, so entering RUN always starts from zero
  always_ff @(posedge SYS_clk or negedge SYS_rst)
    if (!SYS_rst) r_rate <= '0;
    else if (r_state != ST_RUN || w_tc) r_rate <= '0;
    else r_rate <= r_rate + 1'b1;

  // step counter and load value; both are updated on the cycle that enters LOAD
  always_ff @(posedge SYS_clk or negedge SYS_rst)
    if (!SYS_rst) begin
      r_count  <= '0;
      r_pc_val <= '0;
    end else if (w_next == ST_LOAD) begin
      r_count  <= '0;
      r_pc_val <= load_val;
    end else if (w_step_en) begin
      r_count <= r_count + 1'b1;
    end

  assign step_en     = w_step_en;
  assign pc_load     = (r_state == ST_LOAD);
  assign pc_load_val = r_pc_val;
  assign busy        = r_state[1];
  assign step_count  = r_count;
  assign state_o     = r_state;
endmodule

// File: tb/tb_sys_step_ctrl.sv
// tb_sys_step_ctrl: randomized and directed checks of sys_step_ctrl against a behavioural model
module tb_sys_step_ctrl;
  localparam int DB = 4;
  localparam int RD = 16;

  logic       SYS_clk = 1'b0;
  logic       SYS_rst = 1'b0;
  logic       key_step_n = 1'b1;
  logic       sw_run = 1'b0;
  logic       sw_load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [1:0] rate_sel = 2'd0;
  logic [7:0] pc_current = 8'h00;
  logic [7:0] bp_addr = 8'h05;
  logic       bp_valid = 1'b0;
  logic        step_en, pc_load, busy;
  logic [7:0]  pc_load_val;
  logic [15:0] step_count;
  logic [1:0]  state_o;
  logic        d2_step_en, d2_pc_load, d2_busy;
  logic [7:0]  d2_pc_load_val;
  logic [15:0] d2_step_count;
  logic [1:0]  d2_state;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  checking = 0;

  always #5 SYS_clk = ~SYS_clk;

  sys_step_ctrl #(.DEBOUNCE_CYC(DB), .RUN_DIV(RD), .PC_W(8), .CNT_W(16)) u_dut (
    .SYS_clk(SYS_clk), .SYS_rst(SYS_rst), .key_step_n(key_step_n), .sw_run(sw_run),
    .sw_load(sw_load), .load_val(load_val), .rate_sel(rate_sel), .pc_current(pc_current),
`ifdef SYS_STEP_BREAKPOINT_EN
    .bp_addr(bp_addr), .bp_valid(bp_valid),
`endif
    .step_en(step_en), .pc_load(pc_load), .pc_load_val(pc_load_val), .busy(busy),
    .step_count(step_count), .state_o(state_o)
  );

  // second instance with a divider small enough that rate_sel=3 hits the one-cycle clamp
  sys_step_ctrl #(.DEBOUNCE_CYC(DB), .RUN_DIV(4), .PC_W(8), .CNT_W(16)) u_dut2 (
    .SYS_clk(SYS_clk), .SYS_rst(SYS_rst), .key_step_n(key_step_n), .sw_run(sw_run),
    .sw_load(sw_load), .load_val(load_val), .rate_sel(rate_sel), .pc_current(pc_current),
`ifdef SYS_STEP_BREAKPOINT_EN
    .bp_addr(bp_addr), .bp_valid(bp_valid),
`endif
    .step_en(d2_step_en), .pc_load(d2_pc_load), .pc_load_val(d2_pc_load_val), .busy(d2_busy),
    .step_count(d2_step_count), .state_o(d2_state)
  );

  // behavioural model: index 0 = step key, 1 = run switch, 2 = load switch
  int m_s0[3], m_s1[3], m_deb[3], m_prev[3];
  int m_hist[3][DB];
  int m_st, m_el, m_cnt, m_pcv, m_hold;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit m_press();
    return m_prev[0] == 1 && m_deb[0] == 0;
  endfunction

  function automatic bit m_lreq();
    return m_prev[2] == 0 && m_deb[2] == 1;
  endfunction

  function automatic int m_period();
    int p;
    p = RD >> rate_sel;
    return (p == 0) ? 1 : p;
  endfunction

  function automatic bit m_bp();
`ifdef SYS_STEP_BREAKPOINT_EN
    return bp_valid && (pc_current == bp_addr);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_at_tc();
    return m_st == 2 && m_deb[1] == 1 && !m_lreq() && m_el >= m_period() - 1;
  endfunction

  function automatic bit m_step_exp();
    return m_st == 1 || (m_at_tc() && !m_bp());
  endfunction

  task automatic model_reset();
    int rv;
    for (int i = 0; i < 3; i++) begin
      rv = (i == 0) ? 1 : 0;
      m_s0[i] = rv; m_s1[i] = rv; m_deb[i] = rv; m_prev[i] = rv;
      for (int k = 0; k < DB; k++) m_hist[i][k] = rv;
    end
    m_st = 0; m_el = 0; m_cnt = 0; m_pcv = 0; m_hold = 0;
  endtask

  task automatic model_step();
    bit press, lreq, run, runok, tc, pulse, halt, same;
    int raw[3];
    press = m_press();
    lreq  = m_lreq();
    run   = (m_deb[1] == 1);
    runok = run && (m_hold == 0);
    tc    = m_at_tc();
    pulse = m_step_exp();
    halt  = tc && m_bp();
    if (pulse) m_cnt = (m_cnt + 1) % 65536;
    case (m_st)
      0: if (lreq) begin m_st = 3; m_cnt = 0; m_pcv = int'(load_val); end
         else if (runok) begin m_st = 2; m_el = 0; end
         else if (press) m_st = 1;
      1: m_st = 0;
      2: if (lreq) begin m_st = 3; m_cnt = 0; m_pcv = int'(load_val); end
         else if (!run || halt) m_st = 0;
         else m_el = tc ? 0 : m_el + 1;
      default: begin m_st = runok ? 2 : 0; m_el = 0; end
    endcase
    if (halt) m_hold = 1; else if (!run) m_hold = 0;
    raw = '{int'(key_step_n), int'(sw_run), int'(sw_load)};
    for (int i = 0; i < 3; i++) begin
      for (int k = DB - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
      m_hist[i][0] = m_s1[i];
      same = 1;
      for (int k = 1; k < DB; k++) if (m_hist[i][k] != m_hist[i][0]) same = 0;
      m_prev[i] = m_deb[i];
      if (same) m_deb[i] = m_hist[i][0];
      m_s1[i] = m_s0[i];
      m_s0[i] = raw[i];
    end
  endtask

  always @(posedge SYS_clk or negedge SYS_rst)
    if (!SYS_rst) model_reset();
    else model_step();

  always @(negedge SYS_clk)
    if (checking) begin
      check("step_en", int'(step_en), int'(m_step_exp()));
      check("pc_load", int'(pc_load), (m_st == 3) ? 1 : 0);
      check("pc_load_val", int'(pc_load_val), m_pcv);
      check("busy", int'(busy), (m_st >= 2) ? 1 : 0);
      check("step_count", int'(step_count), m_cnt);
      check("state_o", int'(state_o), m_st);
    end

  task automatic tick(input int n);
    repeat (n) @(posedge SYS_clk);
    #2;
  endtask

  task automatic count_pulses(input int n, output int cs, output int cl);
    cs = 0; cl = 0;
    repeat (n) begin
      @(negedge SYS_clk);
      cs += int'(step_en);
      cl += int'(pc_load);
    end
  endtask

  task automatic wait_state(input string name, input int s, input int lim);
    int k;
    k = 0;
    do begin @(negedge SYS_clk); k++; end while (int'(state_o) != s && k < lim);
    check(name, int'(state_o), s);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs, cl, k, c2;
    // reset state
    tick(1);
    checking = 1;
    @(negedge SYS_clk);
    check("rst_state", int'(state_o), 0);
    check("rst_step_count", int'(step_count), 0);
    check("rst_step_en", int'(step_en), 0);
    check("rst_busy", int'(busy), 0);
    tick(2);
    SYS_rst = 1'b1;
    tick(3);
    // 1: glitches shorter than the filter, then one long press
    key_step_n = 0; tick(2); key_step_n = 1; tick(3);
    key_step_n = 0; tick(1); key_step_n = 1; tick(2);
    key_step_n = 0; tick(3); key_step_n = 1; tick(6);
    check("t1_no_glitch_step", int'(step_count), 0);
    key_step_n = 0;
    count_pulses(20, cs, cl);
    tick(1);
    key_step_n = 1;
    count_pulses(12, c2, cl);
    check("t1_one_pulse", cs + c2, 1);
    check("t1_step_count", int'(step_count), 1);
    check("t1_state_idle", int'(state_o), 0);
    // 2: free-run at base rate, then at rate_sel=2
    tick(1);
    sw_run = 1; rate_sel = 0;
    wait_state("t2_enter_run", 2, 20);
    count_pulses(100, cs, cl);
    check("t2_pulses_div16", cs, 6);
    tick(1);
    rate_sel = 2;
    count_pulses(8, cs, cl);
    count_pulses(16, cs, cl);
    check("t2_pulses_div4", cs, 4);
    // 3: load while running
    tick(1);
    load_val = 8'h2A; sw_load = 1;
    k = 0;
    do begin @(negedge SYS_clk); k++; end while (!pc_load && k < 20);
    check("t3_pc_load", int'(pc_load), 1);
    check("t3_pc_load_val", int'(pc_load_val), 'h2A);
    check("t3_count_cleared", int'(step_count), 0);
    check("t3_no_step_with_load", int'(step_en), 0);
    @(negedge SYS_clk);
    check("t3_run_resumes", int'(state_o), 2);
    tick(1);
    sw_load = 0;
    tick(10);
    // 4: load and step edges on the same IDLE cycle
    sw_run = 0;
    wait_state("t4_idle", 0, 20);
    tick(8);
    key_step_n = 0; sw_load = 1; load_val = 8'h3C;
    count_pulses(20, cs, cl);
    check("t4_load_once", cl, 1);
    check("t4_step_dropped", cs, 0);
    check("t4_pc_load_val", int'(pc_load_val), 'h3C);
    count_pulses(20, cs, cl);
    check("t4_held_no_step", cs, 0);
    tick(1);
    key_step_n = 1;
    count_pulses(10, cs, cl);
    tick(1);
    key_step_n = 0;
    count_pulses(12, cs, cl);
    check("t4_new_press_steps", cs, 1);
    tick(1);
    key_step_n = 1; sw_load = 0;
    tick(10);
    // 5: reset one cycle before the terminal count
    rate_sel = 0; sw_run = 1;
    wait_state("t5_enter_run", 2, 20);
    repeat (14) @(negedge SYS_clk);
    check("t5_pre_tc_no_step", int'(step_en), 0);
    #1 SYS_rst = 1'b0;
    #1;
    check("t5_async_step_en", int'(step_en), 0);
    check("t5_async_pc_load", int'(pc_load), 0);
    check("t5_async_pc_load_val", int'(pc_load_val), 0);
    check("t5_async_busy", int'(busy), 0);
    check("t5_async_step_count", int'(step_count), 0);
    check("t5_async_state", int'(state_o), 0);
    sw_run = 0;
    count_pulses(4, cs, cl);
    check("t5_no_pulse_in_reset", cs, 0);
    tick(1);
    SYS_rst = 1'b1;
    tick(10);
`ifdef SYS_STEP_BREAKPOINT_EN
    // 6: breakpoint halts RUN, a single step still works
    bp_addr = 8'h05; pc_current = 8'h05; bp_valid = 1; sw_run = 1;
    wait_state("t6_enter_run", 2, 20);
    cs = 0; k = 0;
    do begin @(negedge SYS_clk); cs += int'(step_en); k++; end while (state_o != 2'd0 && k < 40);
    check("t6_halt_idle", int'(state_o), 0);
    check("t6_suppressed", cs, 0);
    tick(10);
    check("t6_stays_idle", int'(state_o), 0);
    key_step_n = 0;
    count_pulses(12, cs, cl);
    check("t6_step_over", cs, 1);
    tick(1);
    key_step_n = 1; sw_run = 0; bp_valid = 0;
    tick(10);
`endif
    // randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      tick(1);
      if ($urandom_range(9) == 0) key_step_n = ~key_step_n;
      if ($urandom_range(39) == 0) sw_run = ~sw_run;
      if ($urandom_range(24) == 0) sw_load = ~sw_load;
      if ($urandom_range(59) == 0) rate_sel = 2'($urandom_range(3));
      load_val = 8'($urandom);
      pc_current = 8'($urandom_range(7));
`ifdef SYS_STEP_BREAKPOINT_EN
      bp_valid = ($urandom_range(2) == 0);
`endif
    end
    // period clamp: RUN_DIV=4 with rate_sel=3 steps every cycle
    tick(1);
    key_step_n = 1; sw_load = 0; sw_run = 0; rate_sel = 3; bp_valid = 0;
    tick(15);
    sw_run = 1;
    k = 0;
    do begin @(negedge SYS_clk); k++; end while (d2_state != 2'd2 && k < 20);
    check("clamp_enter_run", int'(d2_state), 2);
    cs = 0;
    repeat (20) begin @(negedge SYS_clk); cs += int'(d2_step_en); end
    check("clamp_every_cycle", cs, 20);
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sys_step_ctrl.md
Name: sys_step_ctrl

Overview:
- Clock-enable and PC-load sequencer directly upstream of the single-cycle MIPS core.
- Turns raw board buttons and switches into clean single-cycle strobes: single-step, free-run at a selectable rate, and load-PC-from-switches.
- The core advances only on cycles where step_en is high, so the LCD and hex displays can be inspected between instructions.
- Provides the PC-load path the core currently lacks.

Parameters:
- DEBOUNCE_CYC, 1000000, cycles a raw input must stay stable before it is accepted (20 ms at 50 MHz).
- RUN_DIV, 12500000, base run-mode period in cycles (4 Hz at 50 MHz); rate_sel scales it.
- PC_W, 8, PC width; matches core PC.
- CNT_W, 16, retired-step counter width.

Ports:
- SYS_clk  in  1  system clock, 50 MHz
- SYS_rst  in  1  asynchronous active-low reset
- key_step_n  in  1  raw step push-button, active-low, asynchronous to SYS_clk
- sw_run  in  1  raw switch; 1 = free-run mode
- sw_load  in  1  raw switch; rising edge requests a PC load
- load_val  in  PC_W  PC value from switches
- rate_sel  in  2  run period = RUN_DIV >> rate_sel
- pc_current  in  PC_W  core PC; used only by the optional feature
- step_en  out  1  one-cycle advance enable to core PC/REG/DMEM
- pc_load  out  1  one-cycle PC load strobe
- pc_load_val  out  PC_W  registered copy of load_val, valid while pc_load is high
- busy  out  1  high in RUN or LOAD
- step_count  out  CNT_W  number of step_en pulses since reset or last load
- state_o  out  2  current FSM state, for display

Behaviour:
- Reset (SYS_rst=0, asynchronous):
  - all outputs 0; FSM in IDLE; debouncers hold "released/0".
  - rate counter and step_count cleared.
- Input conditioning:
  - each raw input passes a 2-flop synchroniser, then a debouncer.
  - the debounced value changes only after DEBOUNCE_CYC consecutive identical synchronised samples.
  - edge detect on the debounced value: step_press is a falling edge of key_step_n; load_req is a rising edge of sw_load.
- FSM states: IDLE=0, STEP=1, RUN=2, LOAD=3.
  - IDLE, priority order:
    - load_req -> LOAD
    - else sw_run=1 -> RUN, clearing the rate counter
    - else step_press -> STEP
  - STEP: step_en=1 for exactly one cycle; step_count++; -> IDLE.
  - RUN:
    - rate counter counts 0..(RUN_DIV>>rate_sel)-1.
    - at terminal count: step_en=1 for one cycle, step_count++, counter wraps to 0.
    - sw_run=0 -> IDLE; no further pulse in that cycle.
    - load_req -> LOAD; takes priority; no pulse in that cycle.
    - step_press is ignored.
  - LOAD:
    - pc_load=1 for one cycle; pc_load_val=load_val sampled on the entry cycle; step_count cleared.
    - step_en stays 0 in the same cycle; the two strobes are never high together.
    - -> RUN if sw_run=1, else IDLE.
- Latency:
  - debounced edge to strobe: 1 cycle (edge cycle registers the transition; strobe asserts in the next state).
  - total from raw pin: 2 + DEBOUNCE_CYC + 1 cycles.
- Width and wrap rules:
  - step_count wraps from 2^CNT_W-1 to 0.
  - rate_sel=3 with RUN_DIV>>3 == 0 is clamped to a period of 1, i.e. step_en every cycle.
- Simultaneous events: load beats run beats step.
- Mid-operation reset: aborts any strobe immediately; no partial pulse.
- A button held down produces exactly one step; the next step requires release plus a debounced press.

Optional Feature:
- Macro: SYS_STEP_BREAKPOINT_EN.
- Enabled:
  - extra ports bp_addr [PC_W] and bp_valid [1].
  - in RUN, if bp_valid and pc_current==bp_addr at a terminal count, suppress that step_en and go to IDLE.
  - sw_run must toggle low then high to resume.
  - single STEP from IDLE is unaffected, so a breakpoint can be stepped over.
- Disabled: ports absent; RUN never halts on its own.

Decomposition:
- Shared package sys_pkg holds:
  - state encodings ST_IDLE/ST_STEP/ST_RUN/ST_LOAD
  - default PC_W
  - the clamp helper for the run period
- One natural sub-module, sys_debounce: synchroniser plus stable-count filter plus level output, parameterised by DEBOUNCE_CYC, instantiated three times.

Test Plan:
All scenarios use DEBOUNCE_CYC=4, RUN_DIV=16.
1. Reset then press key_step_n low for 20 cycles with 3 glitches < 4 cycles before it -> exactly one step_en pulse, step_count=1, state returns to 0.
2. sw_run=1, rate_sel=0 for 100 cycles -> step_en every 16 cycles (6 pulses); rate_sel=2 -> every 4 cycles.
3. In RUN, sw_load rising with load_val=8'h2A -> one pc_load, pc_load_val=8'h2A, step_count=0, no step_en in the pc_load cycle, RUN resumes.
4. Debounced load and step edges on the same IDLE cycle -> pc_load only; a step needs a new press.
5. Assert SYS_rst low during RUN one cycle before terminal count -> no step_en; all outputs 0 asynchronously.
6. With SYS_STEP_BREAKPOINT_EN, bp_addr=8'h05, pc_current=8'h05 in RUN -> step_en suppressed, state_o=0; a STEP press then yields one pulse.
